// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared 7-segment tables and widths for the pong score path
package pong_pkg;

    localparam int SEG_W   = 7;
    localparam int SCORE_W = 7;
    localparam int BCD_W   = 4;

    // Segment bit positions inside a SEG_W vector; a 0 in a position lights that segment.
    typedef enum int {
        SEG_A = 0,  // top
        SEG_B = 1,  // upper-right
        SEG_C = 2,  // lower-right
        SEG_D = 3,  // bottom
        SEG_E = 4,  // lower-left
        SEG_F = 5,  // upper-left
        SEG_G = 6   // middle
    } seg_bit_e;

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

    localparam logic [SEG_W-1:0] SEG_DIGIT [0:9] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

endpackage

// File: rtl/score_seg_encoder_if.sv
// rtl/score_seg_encoder_if.sv - game-logic side signals of the score encoder
interface score_seg_encoder_if;
    import pong_pkg::*;

    logic               point;
    logic               clear;
    logic [SEG_W-1:0]   seg_tens;
    logic [SEG_W-1:0]   seg_ones;
    logic [SCORE_W-1:0] score;
    logic               win;

    // Game logic / bench side.
    modport master (
        output point, clear,
        input  seg_tens, seg_ones, score, win
    );

    // Score encoder side.
    modport slave (
        input  point, clear,
        output seg_tens, seg_ones, score, win
    );
endinterface

// File: rtl/bcd_to_seg7.sv
// rtl/bcd_to_seg7.sv - one BCD digit to active-low 7-segment pattern
module bcd_to_seg7
    import pong_pkg::*;
(
    input  logic [BCD_W-1:0] bcd_i,
    output logic [SEG_W-1:0] seg_o
);

    logic [SEG_W-1:0] pat;

    // Table lookup; non-BCD codes fall through to blank.
    always_comb begin
        pat = SEG_BLANK;
        if (bcd_i < 4'd10) begin
            pat = SEG_DIGIT[bcd_i];
        end
        seg_o = SEG_BLANK;
        for (int s = SEG_A; s <= SEG_G; s++) begin
            seg_o[s] = pat[s];
        end
    end

endmodule

// File: rtl/score_seg_encoder.sv
// rtl/score_seg_encoder.sv - two-digit BCD score keeper with 7-seg encode and win flash
module score_seg_encoder
    import pong_pkg::*;
#(
    parameter int WIN_SCORE  = 10,
    parameter bit BLANK_LZ   = 1'b1,
    parameter int FLASH_BITS = 24
) (
    input  logic                clk,
    input  logic                reset,
    score_seg_encoder_if.slave  bus
);

    localparam logic [SCORE_W-1:0] WIN_VAL   = SCORE_W'(WIN_SCORE);
    localparam logic [SEG_W-1:0]   TENS_ZERO = BLANK_LZ ? SEG_BLANK : SEG_DIGIT[0];

    logic                  point_q;
    logic [BCD_W-1:0]      ones_q, ones_d;
    logic [BCD_W-1:0]      tens_q, tens_d;
    logic [SCORE_W-1:0]    score_q, score_d;
    logic                  win_q, win_d;
    logic [FLASH_BITS-1:0] flash_q, flash_d;
    logic [SEG_W-1:0]      seg_tens_q, seg_tens_d;
    logic [SEG_W-1:0]      seg_ones_q, seg_ones_d;
    logic [SEG_W-1:0]      enc_tens, enc_ones;
    logic                  inc;

    bcd_to_seg7 u_enc_tens (.bcd_i(tens_q), .seg_o(enc_tens));
    bcd_to_seg7 u_enc_ones (.bcd_i(ones_q), .seg_o(enc_ones));

    // Next-state: rising-edge scoring with saturation at the win score, flash counter, seg encode.
    always_comb begin
        ones_d     = ones_q;
        tens_d     = tens_q;
        score_d    = score_q;
        win_d      = win_q;
        flash_d    = '0;
        seg_tens_d = seg_tens_q;
        seg_ones_d = seg_ones_q;

        inc = bus.point & ~point_q & ~win_q;

        if (inc) begin
            if (ones_q == 4'd9) begin
                ones_d = '0;
                tens_d = tens_q + 4'd1;
            end else begin
                ones_d = ones_q + 4'd1;
            end
            score_d = score_q + 7'd1;
            win_d   = (score_d == WIN_VAL);
        end

        if (win_q) begin
            flash_d = flash_q + 1'b1;
        end

        if (win_q && flash_q[FLASH_BITS-1]) begin
            seg_tens_d = SEG_BLANK;
            seg_ones_d = SEG_BLANK;
        end else begin
            seg_tens_d = (BLANK_LZ && (tens_q == '0)) ? SEG_BLANK : enc_tens;
            seg_ones_d = enc_ones;
        end
    end

    // State registers; point_q tracks the input even through reset/clear so a level
    // held across them is not mistaken for a fresh edge.
    always_ff @(posedge clk) begin
        point_q <= bus.point;
        if (reset || bus.clear) begin
            ones_q     <= '0;
            tens_q     <= '0;
            score_q    <= '0;
            win_q      <= 1'b0;
            flash_q    <= '0;
            seg_tens_q <= TENS_ZERO;
            seg_ones_q <= SEG_DIGIT[0];
        end else begin
            ones_q     <= ones_d;
            tens_q     <= tens_d;
            score_q    <= score_d;
            win_q      <= win_d;
            flash_q    <= flash_d;
            seg_tens_q <= seg_tens_d;
            seg_ones_q <= seg_ones_d;
        end
    end

    assign bus.seg_tens = seg_tens_q;
    assign bus.seg_ones = seg_ones_q;
    assign bus.score    = score_q;
    assign bus.win      = win_q;

endmodule
